sum_uart_tx: RTL and testbench
==============================

Name: sum_uart_tx

Overview:
- Consumer side of the A/B operand latches: snapshots the two 4-bit latched operands on a send request and adds them.
- Transmits the 5-bit sum over a UART TX line as a 4-byte ASCII record: tens digit, ones digit, CR, LF.
- Sits between the operand latch block and the board TX pin; the send request comes from debounced button logic.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, UART bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD, clocks per UART bit (derived localparam, must be >= 2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- a  input  4  latched operand A (unsigned).
- b  input  4  latched operand B (unsigned).
- send  input  1  transmit request, level; rising edge detected internally.
- tx  output  1  UART serial out, 8N1, LSB first, idle high.
- busy  output  1  high while a record is in flight.
- done  output  1  one-cycle pulse when the record's final stop bit completes.

Behaviour:
- Reset (async, any time, including mid-frame): tx=1, busy=0, done=0, FSM=IDLE, baud counter=0, bit index=0, byte index=0, send edge register=0, snapshot=0.
- Send detection:
  - send_d registered each cycle.
  - Request = send & ~send_d, honoured only in IDLE.
  - Requests while busy are dropped, not queued.
  - Holding send high does not retrigger.
- On an accepted request edge:
  - sum = a + b captured as 5 bits (range 0..30).
  - tens = 3 if sum>=30, 2 if sum>=20, 1 if sum>=10, else 0; ones = sum - 10*tens.
  - Bytes fixed as 0x30+tens, 0x30+ones, 0x0D, 0x0A.
  - Later changes on a/b do not affect the record in flight.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, busy=0. Accepted request -> START on the same edge; busy=1 and tx=0 are registered from that edge.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA, bit index=0.
  - DATA: tx=current byte[bit index], each bit held CLKS_PER_BIT cycles, LSB first. After bit 7 -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If byte index<3: increment byte index -> START directly, with no idle gap between bytes.
    - If byte index=3: -> IDLE with busy=0 and done=1 for exactly one cycle.
- Timing:
  - Record length is exactly 40*CLKS_PER_BIT cycles, from the first tx-low cycle to the cycle busy deasserts.
  - The first tx-low cycle is the cycle after the clk edge that samples the send rise.
- Baud counter: counts 0..CLKS_PER_BIT-1, reloads to 0 on every bit boundary and state change; it never free-runs in IDLE.
- A new request is accepted on the same cycle done is high: FSM is IDLE and send_d is low.
- All outputs are registered; no combinational path from a, b or send to tx.

Test Plan (sim with CLK_FREQ=16, BAUD=1, so CLKS_PER_BIT=16):
- Reset, then idle 50 cycles -> tx=1, busy=0, done never pulses.
- a=9, b=7, pulse send -> serial decode gives 0x31, 0x36, 0x0D, 0x0A. Busy high for exactly 640 cycles; done is a single one-cycle pulse at the end.
- a=15, b=15 -> 0x33, 0x30, 0x0D, 0x0A. Then a=0, b=0 -> 0x30, 0x30, 0x0D, 0x0A.
- a=3, b=4, send, then change a=15 after 5 cycles and pulse send twice during the record -> exactly one record, "07" + CR + LF. No second record starts after done.
- Assert reset at cycle 200 of a record, release at 210 -> tx=1 and busy=0 within reset. A following send (a=1, b=1) yields a clean "02" + CR + LF.
- Hold send high for 2000 cycles -> exactly one record is transmitted.

Source files
------------

// File: rtl/sum_uart_tx.sv
// Adds two latched 4-bit operands on a send request and transmits the sum
// as a four-byte ASCII record (tens, ones, CR, LF) over an 8N1 UART line.
module sum_uart_tx #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       send,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    // CLKS_PER_BIT must be at least 2.
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [4:0]       sum_q, sum_d;
    logic             send_d_q;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             req;
    logic             last_tick;
    logic [1:0]       tens;
    logic [3:0]       ones;
    logic [7:0]       cur_byte;
    logic [2:0]       bit_next;

    assign req       = send & ~send_d_q;
    assign last_tick = (cnt_q == CNT_LAST);
    assign bit_next  = bit_idx_q + 3'd1;

    always_comb begin
        tens = 2'd0;
        ones = sum_q[3:0];
        if (sum_q >= 5'd30) begin
            tens = 2'd3;
            ones = 4'(sum_q - 5'd30);
        end else if (sum_q >= 5'd20) begin
            tens = 2'd2;
            ones = 4'(sum_q - 5'd20);
        end else if (sum_q >= 5'd10) begin
            tens = 2'd1;
            ones = 4'(sum_q - 5'd10);
        end
    end

    always_comb begin
        cur_byte = 8'h0A;
        unique case (byte_idx_q)
            2'd0: cur_byte = {6'b0011_00, tens};
            2'd1: cur_byte = {4'h3, ones};
            2'd2: cur_byte = 8'h0D;
            2'd3: cur_byte = 8'h0A;
        endcase
    end

    // tx_d is the line level for the cycle after this edge, so tx stays registered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        sum_d      = sum_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
                if (req) begin
                    state_d    = StStart;
                    bit_idx_d  = 3'd0;
                    byte_idx_d = 2'd0;
                    sum_d      = {1'b0, a} + {1'b0, b};
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            StStart: begin
                if (last_tick) begin
                    state_d   = StData;
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    tx_d      = cur_byte[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StData: begin
                if (last_tick) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_next;
                        tx_d      = cur_byte[bit_next];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStop: begin
                if (last_tick) begin
                    cnt_d = '0;
                    if (byte_idx_q == 2'd3) begin
                        state_d    = StIdle;
                        byte_idx_d = 2'd0;
                        tx_d       = 1'b1;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        state_d    = StStart;
                        byte_idx_d = byte_idx_q + 2'd1;
                        tx_d       = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 2'd0;
            sum_q      <= 5'd0;
            send_d_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            sum_q      <= sum_d;
            send_d_q   <= send;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_sum_uart_tx.sv
// Directed bench for sum_uart_tx: decodes the serial record and checks
// timing, request filtering and reset recovery.
module tb_sum_uart_tx;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic       send = 1'b0;
    logic       tx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    int busy_cyc = 0;
    int done_cnt = 0;
    int starts = 0;
    int tx_low = 0;
    logic busy_prev = 1'b0;

    sum_uart_tx #(
        .CLK_FREQ(16),
        .BAUD    (1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .a    (a),
        .b    (b),
        .send (send),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        busy_prev <= busy;
        if (busy && !busy_prev) starts <= starts + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (!tx) tx_low <= tx_low + 1;
    end

    task automatic get_byte(output logic [7:0] d, output bit ok);
        int n;
        ok = 1'b1;
        d  = 8'h00;
        n  = 0;
        while (tx !== 1'b0 && n < 40 * C) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        repeat (C / 2) @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (C) @(negedge clk);
            d[i] = tx;
        end
        repeat (C) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic get_record(output logic [31:0] rec, output bit ok);
        logic [7:0] d;
        bit         bok;
        ok  = 1'b1;
        rec = 32'h0;
        for (int i = 0; i < 4; i++) begin
            get_byte(d, bok);
            if (!bok) ok = 1'b0;
            rec = {rec[23:0], d};
        end
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50 * C) begin
            @(negedge clk);
            n++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic test_reset();
        int d0, l0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: tx=%b busy=%b done=%b, required 1 0 0", tx, busy, done);
        end
        reset = 1'b0;
        d0 = done_cnt;
        l0 = tx_low;
        repeat (50) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: tx=%b busy=%b, required 1 0", tx, busy);
        end
        checks++;
        if (done_cnt - d0 != 0 || tx_low - l0 != 0) begin
            errors++;
            $display("FAIL idle_quiet: done pulses=%0d tx low cycles=%0d, required 0 0",
                     done_cnt - d0, tx_low - l0);
        end
    endtask

    task automatic test_record(input logic [3:0] va, input logic [3:0] vb,
                               input logic [31:0] exp_rec, input string name);
        logic [31:0] rec;
        bit          ok, iok;
        int          b0, d0;
        b0 = busy_cyc;
        d0 = done_cnt;
        @(negedge clk);
        a    = va;
        b    = vb;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_start: tx=%b busy=%b, required 0 1", name, tx, busy);
        end
        get_record(rec, ok);
        wait_idle(iok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || !iok) begin
            errors++;
            $display("FAIL %s_framing: framing ok=%0d idle ok=%0d, required 1 1", name, ok, iok);
        end
        checks++;
        if (rec !== exp_rec) begin
            errors++;
            $display("FAIL %s_data: got %h, required %h", name, rec, exp_rec);
        end
        checks++;
        if (busy_cyc - b0 != 40 * C) begin
            errors++;
            $display("FAIL %s_busy_len: got %0d, required %0d", name, busy_cyc - b0, 40 * C);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL %s_done: done cycles=%0d, required 1", name, done_cnt - d0);
        end
    endtask

    task automatic test_ignore_requests();
        logic [31:0] rec;
        bit          ok, iok;
        int          s0, d0;
        s0 = starts;
        d0 = done_cnt;
        @(negedge clk);
        a    = 4'd3;
        b    = 4'd4;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        fork
            get_record(rec, ok);
            begin
                repeat (4) @(negedge clk);
                a = 4'd15;
                repeat (100) @(negedge clk);
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
                repeat (200) @(negedge clk);
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
            end
        join
        wait_idle(iok);
        repeat (800) @(negedge clk);
        checks++;
        if (!ok || !iok || rec !== 32'h3037_0D0A) begin
            errors++;
            $display("FAIL ignore_data: got %h ok=%0d idle=%0d, required 30370d0a 1 1",
                     rec, ok, iok);
        end
        checks++;
        if (starts - s0 != 1 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL ignore_count: starts=%0d done=%0d, required 1 1",
                     starts - s0, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        a    = 4'd9;
        b    = 4'd9;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (199) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: tx=%b busy=%b done=%b, required 1 0 0",
                     tx, busy, done);
        end
        repeat (10) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done_cnt - d0 != 0) begin
            errors++;
            $display("FAIL midreset_after: tx=%b busy=%b done=%0d, required 1 0 0",
                     tx, busy, done_cnt - d0);
        end
        test_record(4'd1, 4'd1, 32'h3032_0D0A, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [31:0] rec;
        bit          ok;
        int          n;
        @(negedge clk);
        a    = 4'd2;
        b    = 4'd3;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 50 * C) begin
            @(negedge clk);
            n++;
        end
        a    = 4'd4;
        b    = 4'd4;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: tx=%b busy=%b, required 0 1", tx, busy);
        end
        get_record(rec, ok);
        checks++;
        if (!ok || rec !== 32'h3038_0D0A) begin
            errors++;
            $display("FAIL b2b_data: got %h ok=%0d, required 30380d0a 1", rec, ok);
        end
        wait_idle(ok);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_hold_send();
        int s0, d0;
        s0 = starts;
        d0 = done_cnt;
        @(negedge clk);
        a    = 4'd2;
        b    = 4'd5;
        send = 1'b1;
        repeat (2000) @(negedge clk);
        send = 1'b0;
        repeat (700) @(negedge clk);
        checks++;
        if (starts - s0 != 1 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL hold_count: starts=%0d done=%0d, required 1 1",
                     starts - s0, done_cnt - d0);
        end
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle: tx=%b busy=%b, required 1 0", tx, busy);
        end
    endtask

    initial begin
        test_reset();
        test_record(4'd9, 4'd7, 32'h3136_0D0A, "sum16");
        test_record(4'd15, 4'd15, 32'h3330_0D0A, "sum30");
        test_record(4'd0, 4'd0, 32'h3030_0D0A, "sum0");
        test_ignore_requests();
        test_reset_mid_frame();
        test_back_to_back();
        test_hold_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
